// File: rtl/leb128_pkg.sv
// rtl/leb128_pkg.sv - shared types and helpers for the LEB128 stream decoder
package leb128_pkg;

  localparam int LEB128_CONT = 7;

  typedef enum logic [1:0] {
    ACC,
    SKIP,
    OUT
  } leb128_state_t;

  function automatic int leb128_maxb(input int n);
    return (n + 6) / 7;
  endfunction

endpackage

// File: rtl/leb128_final_merge.sv
// rtl/leb128_final_merge.sv - merges one 7-bit group into the accumulator, sign-extends, range-checks
module leb128_final_merge
  import leb128_pkg::*;
#(
  parameter int N      = 32,
  parameter bit SIGNED = 1'b0,
  localparam int MAXB  = leb128_maxb(N),
  localparam int LW    = $clog2(MAXB + 1)
) (
  input  logic [N-1:0]  acc,
  input  logic [6:0]    payload,
  input  logic [LW-1:0] cnt,
  output logic [N-1:0]  merged,
  output logic [N-1:0]  value,
  output logic          range_err
);

  // Bits of the last legal byte that still land inside the N-bit result.
  localparam int K = N - 7 * (MAXB - 1);

  int unsigned idx;
  logic [N-1:0] ext_mask;
  logic         ext_en;
  logic         viol;

  always_comb begin
    idx      = 32'(cnt);
    merged   = acc | (N'(payload) << (7 * idx));
    ext_mask = {N{1'b1}} << (7 * (idx + 1));
    ext_en   = SIGNED && payload[6] && ((7 * (idx + 1)) < N);
    value    = ext_en ? (merged | ext_mask) : merged;
  end

  if (K < 7) begin : g_range
    logic [6-K:0] hi;
    assign hi = payload[6:K];
    if (SIGNED) begin : g_signed
      // Discarded high bits must replicate the result's sign bit.
      assign viol = (hi != {(7 - K){payload[K-1]}});
    end else begin : g_unsigned
      assign viol = |hi;
    end
  end else begin : g_no_range
    assign viol = 1'b0;
  end

  assign range_err = viol && (cnt == LW'(MAXB - 1));

endmodule

// File: rtl/leb128_stream_decoder.sv
// rtl/leb128_stream_decoder.sv - byte-serial LEB128/SLEB128 decoder with overlong/range error flag
module leb128_stream_decoder
  import leb128_pkg::*;
#(
  parameter int N      = 32,
  parameter bit SIGNED = 1'b0,
  localparam int MAXB  = leb128_maxb(N),
  localparam int LW    = $clog2(MAXB + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic [LW-1:0] out_len,
  output logic          out_err,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [LW-1:0] LAST = LW'(MAXB - 1);

  leb128_state_t state, state_n;
  logic [N-1:0]  acc, acc_n, data_n;
  logic [LW-1:0] cnt, cnt_n, len_n;
  logic          err_n;
  logic          take, cont;
  logic [N-1:0]  merged, value;
  logic          range_err;

  leb128_final_merge #(
    .N      (N),
    .SIGNED (SIGNED)
  ) u_merge (
    .acc       (acc),
    .payload   (in_data[6:0]),
    .cnt       (cnt),
    .merged    (merged),
    .value     (value),
    .range_err (range_err)
  );

  assign in_ready  = (state == ACC) || (state == SKIP);
  assign out_valid = (state == OUT);
  assign take      = in_valid && in_ready;
  assign cont      = in_data[LEB128_CONT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_len  <= '0;
      out_err  <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      out_data <= data_n;
      out_len  <= len_n;
      out_err  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    data_n  = out_data;
    len_n   = out_len;
    err_n   = out_err;
    case (state)
      ACC: begin
        if (take) begin
          if (!cont) begin
            state_n = OUT;
            if (range_err) begin
              data_n = '0;
              len_n  = LW'(MAXB);
              err_n  = 1'b1;
            end else begin
              data_n = value;
              len_n  = cnt + LW'(1);
              err_n  = 1'b0;
            end
          end else if (cnt == LAST) begin
            // Too many bytes: swallow the remainder and report one error.
            state_n = SKIP;
            acc_n   = '0;
            cnt_n   = '0;
          end else begin
            acc_n = merged;
            cnt_n = cnt + LW'(1);
          end
        end
      end
      SKIP: begin
        if (take && !cont) begin
          state_n = OUT;
          data_n  = '0;
          len_n   = LW'(MAXB);
          err_n   = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_n = ACC;
          acc_n   = '0;
          cnt_n   = '0;
          err_n   = 1'b0;
        end
      end
      default: begin
        state_n = ACC;
      end
    endcase
  end

endmodule
